// File: rtl/fifo_fill_ctrl_if.sv
// FIFO write-side bundle between the fill controller (master) and the FIFO (slave).
// The FIFO reports occupancy and full; the controller drives the write strobe and data.
interface fifo_fill_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_words;
  logic              wr_en;
  logic [DATA_W-1:0] fifo_data;

  modport master (
    input  fifo_full,
    input  fifo_words,
    output wr_en,
    output fifo_data
  );

  modport slave (
    output fifo_full,
    output fifo_words,
    input  wr_en,
    input  fifo_data
  );
endinterface

// File: rtl/fifo_fill_ctrl.sv
// Watermark-driven FIFO filler: writes a generated data pattern while in FILL,
// pauses in HOLD between the high and low watermarks, and counts accepted writes.
module fifo_fill_ctrl #(
  parameter int                DATA_W  = 8,
  parameter int                CNT_W   = 4,
  parameter logic [DATA_W-1:0] PATTERN = 8'hAA,
  parameter int                HI_DEF  = 5,
  parameter int                LO_DEF  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               cfg_load,
  input  logic [CNT_W-1:0]   hi_thr,
  input  logic [CNT_W-1:0]   lo_thr,
  input  logic               cnt_clr,
  fifo_fill_ctrl_if.master   fifo,
  output logic [1:0]         state_o,
  output logic [15:0]        wr_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam logic [1:0] MODE_CONST = 2'b00;
  localparam logic [1:0] MODE_INC   = 2'b01;
  localparam logic [1:0] MODE_WALK  = 2'b10;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  hi_q;
  logic [CNT_W-1:0]  lo_q;
  logic [1:0]        mode_eff;
  logic              wr_en;
  logic              cfg_ok;

  function automatic logic [DATA_W-1:0] seed_data(input logic [1:0] m);
    case (m)
      MODE_INC:  return '0;
      MODE_WALK: return {{(DATA_W-1){1'b0}}, 1'b1};
      default:   return PATTERN;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] next_data(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        m);
    case (m)
      MODE_INC:  return d + DATA_W'(1);
      MODE_WALK: return {d[DATA_W-2:0], d[DATA_W-1]};
      default:   return d;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Mode 11 is an alias of the constant pattern; normalise before latching.
  assign mode_eff = (mode == 2'b11) ? MODE_CONST : mode;
  assign cfg_ok   = (lo_thr < hi_thr);

  // State reset is asynchronous, so the write strobe falls as soon as rst_n does.
  assign wr_en        = (state_q == FILL) && !fifo.fifo_full;
  assign fifo.wr_en   = wr_en;
  assign fifo.fifo_data = data_q;
  assign state_o      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_CONST;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= FILL;
            mode_q  <= mode_eff;
          end
        end
        FILL: begin
          if (!en)                    state_q <= IDLE;
          else if (fifo.fifo_words >= hi_q) state_q <= HOLD;
        end
        HOLD: begin
          if (!en)                    state_q <= IDLE;
          else if (fifo.fifo_words <= lo_q) state_q <= FILL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data is seeded on IDLE->FILL and only advances on accepted writes, which
  // can only happen in FILL, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= PATTERN;
    end else if (state_q == IDLE && en) begin
      data_q <= seed_data(mode_eff);
    end else if (wr_en) begin
      data_q <= next_data(data_q, mode_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= 16'd0;
    end else if (cnt_clr) begin
      wr_count <= 16'd0;
    end else if (wr_en) begin
      wr_count <= sat_inc(wr_count);
    end
  end

  // A rejected load keeps the old watermarks and leaves the sticky error set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= CNT_W'(HI_DEF);
      lo_q    <= CNT_W'(LO_DEF);
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        hi_q    <= hi_thr;
        lo_q    <= lo_thr;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Scoreboard bench for fifo_fill_ctrl: a behavioural model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares against the DUT.
module tb_fifo_fill_ctrl;

  localparam logic [7:0] PAT = 8'hAA;

  logic       clk = 1'b1;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       cfg_load = 1'b0;
  logic [3:0] hi_thr = 4'd0;
  logic [3:0] lo_thr = 4'd0;
  logic       cnt_clr = 1'b0;
  logic [1:0] state_o;
  logic [15:0] wr_count;
  logic       cfg_err;

  fifo_fill_ctrl_if #(.DATA_W(8), .CNT_W(4)) fif ();

  fifo_fill_ctrl #(
    .DATA_W(8), .CNT_W(4), .PATTERN(PAT), .HI_DEF(5), .LO_DEF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .cfg_load(cfg_load), .hi_thr(hi_thr), .lo_thr(lo_thr), .cnt_clr(cnt_clr),
    .fifo(fif), .state_o(state_o), .wr_count(wr_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        wr;
    logic [7:0]  d;
    logic [15:0] c;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model state: state as spec code, writes since the last FILL entry, total writes.
  int m_st, m_mode, m_nw, m_total, m_hi, m_lo;
  bit m_err;

  function automatic void m_reset();
    m_st = 0; m_mode = 0; m_nw = 0; m_total = 0; m_hi = 5; m_lo = 2; m_err = 0;
  endfunction

  function automatic logic [7:0] m_data();
    case (m_mode)
      1: return 8'(m_nw % 256);
      2: return 8'(1 << (m_nw % 8));
      default: return PAT;
    endcase
  endfunction

  function automatic bit m_wr();
    return rst_n && (m_st == 1) && !fif.fifo_full;
  endfunction

  task automatic model_edge();
    bit wr;
    int w, nst;
    if (!rst_n) return;
    wr = m_wr();
    w = int'(fif.fifo_words);
    nst = m_st;
    if (cnt_clr) m_total = 0;
    else if (wr && m_total < 65535) m_total = m_total + 1;
    if (wr) m_nw = m_nw + 1;
    case (m_st)
      0: if (en) begin nst = 1; m_mode = (mode == 2'd3) ? 0 : int'(mode); m_nw = 0; end
      1: if (!en) nst = 0; else if (w >= m_hi) nst = 2;
      2: if (!en) nst = 0; else if (w <= m_lo) nst = 1;
      default: nst = 0;
    endcase
    if (cfg_load) begin
      if (int'(lo_thr) < int'(hi_thr)) begin
        m_hi = int'(hi_thr); m_lo = int'(lo_thr); m_err = 0;
      end else begin
        m_err = 1;
      end
    end
    m_st = nst;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.st  = 2'(m_st);
    e.wr  = m_wr();
    e.d   = m_data();
    e.c   = 16'(m_total);
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input bit e, input logic [1:0] md, input int w, input bit full,
                     input bit ld = 0, input int hi = 0, input int lo = 0,
                     input bit clr = 0);
    en = e; mode = md;
    fif.fifo_words = 4'(w); fif.fifo_full = full;
    cfg_load = ld; hi_thr = 4'(hi); lo_thr = 4'(lo); cnt_clr = clr;
    push_exp();
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state",    16'(state_o),       16'(e.st));
      chk("wr_en",    16'(fif.wr_en),     16'(e.wr));
      chk("data",     16'(fif.fifo_data), 16'(e.d));
      chk("wr_count", wr_count,           e.c);
      chk("cfg_err",  16'(cfg_err),       16'(e.err));
    end
  end

  initial begin
    fif.fifo_full = 1'b0;
    fif.fifo_words = 4'd0;
    m_reset();
    #1 rst_n = 1'b0;
    repeat (3) cyc(1, 2'd1, 0, 0);
    rst_n = 1'b1;
    cyc(0, 2'd0, 0, 0);

    // Constant mode: ramp to the high watermark then drain to the low one.
    cyc(1, 2'd0, 0, 0);
    for (int w = 0; w <= 5; w++) cyc(1, 2'd0, w, 0);
    for (int w = 5; w >= 1; w--) cyc(1, 2'd0, w, 0);
    cyc(1, 2'd3, 2, 0);
    cyc(0, 2'd0, 2, 0);

    // Incrementing mode, count cleared on entry, then a full cycle.
    cyc(1, 2'd1, 0, 0, 0, 0, 0, 1);
    repeat (4) cyc(1, 2'd1, 1, 0);
    cyc(1, 2'd2, 1, 1);
    cyc(1, 2'd1, 1, 1);
    cyc(0, 2'd0, 1, 0);

    // Walking-one: nine writes wrap back to 01, then stall on full.
    cyc(1, 2'd2, 0, 0);
    repeat (9) cyc(1, 2'd2, 0, 0);
    repeat (2) cyc(1, 2'd0, 0, 1);
    cyc(0, 2'd0, 0, 0);

    // Rejected then accepted watermark loads.
    cyc(0, 2'd0, 0, 0, 1, 3, 3);
    cyc(0, 2'd0, 0, 0);
    cyc(1, 2'd0, 0, 0);
    for (int w = 0; w <= 5; w++) cyc(1, 2'd0, w, 0);
    cyc(1, 2'd0, 4, 0, 1, 7, 1);
    for (int w = 3; w >= 1; w--) cyc(1, 2'd0, w, 0);
    for (int w = 2; w <= 7; w++) cyc(1, 2'd0, w, 0);
    cyc(1, 2'd0, 7, 0);
    cyc(1, 2'd0, 2, 0);

    // en low in HOLD beats the low-watermark transition.
    cyc(0, 2'd0, 1, 0);
    cyc(0, 2'd0, 1, 0);

    // Asynchronous reset in the middle of FILL.
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd1, 0, 0);
    chk("wr_en_before_rst", 16'(fif.wr_en), 16'd1);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("wr_en_async_rst", 16'(fif.wr_en), 16'd0);
    chk("wr_count_async_rst", wr_count, 16'd0);
    repeat (2) cyc(1, 2'd1, 0, 0);
    rst_n = 1'b1;
    cyc(0, 2'd0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 8) != 0, 2'($urandom % 4), int'($urandom % 16),
          ($urandom % 6) == 0, ($urandom % 20) == 0,
          int'($urandom % 16), int'($urandom % 16), ($urandom % 25) == 0);
    end

    // Saturation of wr_count, then clear colliding with a write.
    cyc(0, 2'd0, 0, 0);
    cyc(1, 2'd1, 0, 0, 0, 0, 0, 1);
    repeat (65536) cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd1, 0, 0, 0, 0, 0, 1);
    cyc(1, 2'd1, 0, 1);
    cyc(0, 2'd0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
